// File: rtl/mux4_xfer_ctrl.sv
// Two-port register-transfer sequencer driving mux4 select and A/B/C/D load enables.
// Define MUX4_XFER_CTRL_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mux4_xfer_ctrl #(
  parameter int HOLD_CYCLES = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req_valid,
  input  logic [1:0] i_req_src0,
  input  logic [1:0] i_req_src1,
  input  logic [1:0] i_req_dst0,
  input  logic [1:0] i_req_dst1,
  output logic [1:0] o_req_ready,
  output logic [1:0] o_reg_sel4,
  output logic       o_a_load,
  output logic       o_b_load,
  output logic       o_c_load,
  output logic       o_d_load,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_done_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LOAD_A,
    S_WRITE_DST,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_src;
  logic [1:0] r_dst;
  logic       r_id;
  logic [3:0] r_cnt;
  logic       w_any;
  logic       w_grant;
  logic       w_accept;

  assign w_any    = |i_req_valid;
  assign w_accept = (r_state == S_IDLE) && w_any;

`ifdef MUX4_XFER_CTRL_RR_EN
  logic r_ptr;

  // Pointer only matters on contention; a lone request always wins.
  assign w_grant = (&i_req_valid) ? r_ptr : ~i_req_valid[0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_grant;
    end
  end
`else
  assign w_grant = ~i_req_valid[0];
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_src   <= 2'd0;
      r_dst   <= 2'd0;
      r_id    <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src <= w_grant ? i_req_src1 : i_req_src0;
        r_dst <= w_grant ? i_req_dst1 : i_req_dst0;
        r_id  <= w_grant;
        r_cnt <= 4'(HOLD_CYCLES - 1);
      end else if (r_state == S_SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 2'b00;
    o_reg_sel4  = 2'd0;
    o_a_load    = 1'b0;
    o_b_load    = 1'b0;
    o_c_load    = 1'b0;
    o_d_load    = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_done      = 1'b0;
    o_done_id   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready is masked while reset is held so nothing looks accepted.
        if (w_any && !i_reset) begin
          o_req_ready = w_grant ? 2'b10 : 2'b01;
        end
        if (w_any) begin
          w_next = (HOLD_CYCLES > 0) ? S_SETTLE : S_LOAD_A;
        end
      end
      S_SETTLE: begin
        o_reg_sel4 = r_src;
        if (r_cnt == 4'd0) begin
          w_next = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        o_reg_sel4 = r_src;
        o_a_load   = 1'b1;
        w_next     = (r_dst != 2'd0) ? S_WRITE_DST : S_DONE;
      end
      S_WRITE_DST: begin
        o_b_load = (r_dst == 2'd1);
        o_c_load = (r_dst == 2'd2);
        o_d_load = (r_dst == 2'd3);
        w_next   = S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        o_done_id = r_id;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/mux4_xfer_ctrl.md
# mux4_xfer_ctrl

Sequencer and arbiter for the 8-bit CPU's accumulator input path. It accepts register-transfer requests from two requesters: port 0 is the instruction decoder and port 1 is the debug/monitor interface. It grants one request at a time and drives `mux4`'s `reg_sel4` together with the A/B/C/D register load enables. A transfer first latches the selected source into A through `mux4`, then optionally copies A into the destination register.

## Interface
- `HOLD_CYCLES`, default 0: extra cycles `reg_sel4` is held stable before `a_load`. Legal range 0–15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-port request valid; bit 0 is the decoder, bit 1 is debug.
- `req_src0`, `req_src1`  in  2 each  source select: 0 = alu_out, 1 = B, 2 = C, 3 = D.
- `req_dst0`, `req_dst1`  in  2 each  destination: 0 = A, 1 = B, 2 = C, 3 = D.
- `req_ready`  out  2  one-hot accept strobe; the request is taken on the edge where `req_valid[i] & req_ready[i]`.
- `reg_sel4`  out  2  select driven to `mux4`.
- `a_load`, `b_load`, `c_load`, `d_load`  out  1 each  register load enables (B/C/D load from `Aout`).
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  1  port whose transfer completed; valid only while `done` is high.

## Operation
- States: IDLE, SETTLE, LOAD_A, WRITE_DST, DONE.
- **IDLE**
  - `req_ready[g]` is high combinationally for the granted port `g` when any `req_valid` bit is set.
  - On the accept edge, latch `src`, `dst` and `id = g`.
  - Next state is SETTLE if `HOLD_CYCLES > 0`, otherwise LOAD_A.
- **SETTLE**
  - `reg_sel4 = src`.
  - A 4-bit counter loads `HOLD_CYCLES-1` on entry and decrements each cycle.
  - Move to LOAD_A when the count reaches 0.
- **LOAD_A**
  - `reg_sel4 = src` and `a_load = 1` for exactly one cycle.
  - Next state is WRITE_DST if `dst != 0`, else DONE.
- **WRITE_DST**
  - Exactly one of `b_load`/`c_load`/`d_load` (per `dst`) is high for one cycle.
  - `reg_sel4 = 0`.
  - Next state is DONE.
- **DONE**
  - `done = 1` and `done_id = id` for one cycle, then IDLE.
- **Arbitration (fixed priority)**
  - Port 0 wins whenever `req_valid[0]` is set.
  - Port 1 is granted only when `req_valid[0] = 0`.
- Outside SETTLE/LOAD_A, `reg_sel4 = 0`. All load enables are 0 except as listed above.
- `src == dst` is not special-cased.
  - src = B, dst = B still performs both LOAD_A and WRITE_DST.
  - src = 0, dst = 0 loads `alu_out` into A and skips WRITE_DST.
- Requester inputs are ignored outside IDLE. Requesters must hold `req_valid`/`src`/`dst` stable until accepted.

## Timing
- Reset state: IDLE.
- Reset values: `reg_sel4 = 0`; `a_load`, `b_load`, `c_load`, `d_load`, `busy`, `done` = 0; `done_id = 0`; `req_ready = 0`; round-robin pointer → port 0.
- Latency from the accept edge, with `H = HOLD_CYCLES`:
  - `a_load` is high in cycle H+1.
  - The dst load, if any, is high in cycle H+2.
  - `done` is high in cycle H+3, or H+2 when `dst = 0`.
- A new accept can occur in the cycle after `done`. `req_ready` is never high during the `done` cycle.
- Throughput with H = 0: 4 cycles per transfer when `dst != A`, 3 when `dst = A`.
- Reset asserted mid-transfer:
  - All outputs drop immediately (asynchronously).
  - The transfer is discarded with no `done` pulse.
  - Requesters must re-present the request.
- Simultaneous requests on both ports resolve in the same cycle; only one `req_ready` bit is ever high.

## Configuration
- `MUX4_XFER_CTRL_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - After each accept, the pointer moves to the non-granted port.
  - A lone request is granted regardless of the pointer.
- Undefined: fixed priority, port 0 first; the pointer logic is not present.

## Test plan
- Reset, then port 0 requests src = 2, dst = 0, H = 0:
  - `req_ready = 2'b01` in the request cycle.
  - Next cycle: `reg_sel4 = 2`, `a_load = 1`.
  - Following cycle: `done = 1`, `done_id = 0`. No B/C/D load.
- Port 1 requests src = 3, dst = 1, H = 2:
  - `reg_sel4 = 3` for 3 cycles, with `a_load` in the third.
  - Then `b_load` for 1 cycle, then `done` with `done_id = 1`.
  - Total 5 cycles after accept.
- Both ports hold `req_valid = 2'b11` for 3 transfers:
  - Fixed build grants 0, 0, 0.
  - With `MUX4_XFER_CTRL_RR_EN`: grants 0, 1, 0.
- src = B, dst = B: `a_load` with `reg_sel4 = 1`, then `b_load`, then `done`. No other enables.
- Reset asserted during the WRITE_DST cycle:
  - `d_load` and `busy` go to 0 immediately.
  - No `done` follows.
  - After release, `req_ready` is asserted for the still-pending request.
- Back-to-back requests with H = 0, dst = C: accepts are exactly 4 cycles apart. `busy` drops only in the cycle between `done` and the next accept edge.
